// File: rtl/boot_loader.sv
// Streams a length-prefixed, checksummed image into core memory and holds the core in reset
// until a complete image with a matching checksum has been written.
module boot_loader #(
  parameter int unsigned           ADDR_WIDTH = 13,
  parameter int unsigned           DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  restart,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  core_rst,
  output logic                  done,
  output logic                  error,
  output logic [ADDR_WIDTH-1:0] byte_count
);

  // Upper length bits carried in the LEN_HI byte; the remaining high bits must be zero.
  localparam int unsigned HiBits = ADDR_WIDTH - DATA_WIDTH;

  typedef enum logic [2:0] {
    StIdle,
    StLenHi,
    StLenLo,
    StData,
    StCheck,
    StDone,
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;
  logic [ADDR_WIDTH-1:0] byte_count_q, byte_count_d;
  logic [ADDR_WIDTH-1:0] mem_address_q, mem_address_d;
  logic [DATA_WIDTH-1:0] mem_write_data_q, mem_write_data_d;
  logic                  mem_write_q, mem_write_d;
  logic                  core_rst_q, core_rst_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic                  xfer;
  logic [ADDR_WIDTH-1:0] len_lo_next;

  always_comb begin
    in_ready = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StData, StCheck: in_ready = 1'b1;
      default:                           in_ready = 1'b0;
    endcase
  end

  assign xfer        = in_valid & in_ready;
  assign len_lo_next = {len_q[ADDR_WIDTH-1:DATA_WIDTH], in_data};

  always_comb begin
    state_d          = state_q;
    len_d            = len_q;
    sum_d            = sum_q;
    byte_count_d     = byte_count_q;
    mem_address_d    = mem_address_q;
    mem_write_data_d = mem_write_data_q;
    mem_write_d      = 1'b0;
    core_rst_d       = core_rst_q;
    done_d           = done_q;
    error_d          = error_q;

    unique case (state_q)
      StIdle: state_d = StLenHi;

      StLenHi: begin
        if (xfer) begin
          if (in_data[DATA_WIDTH-1:HiBits] != '0) begin
            state_d    = StError;
            error_d    = 1'b1;
            core_rst_d = 1'b1;
          end else begin
            len_d   = {in_data[HiBits-1:0], len_q[DATA_WIDTH-1:0]};
            state_d = StLenLo;
          end
        end
      end

      StLenLo: begin
        if (xfer) begin
          len_d   = len_lo_next;
          state_d = (len_lo_next == '0) ? StCheck : StData;
        end
      end

      StData: begin
        if (xfer) begin
          mem_write_d      = 1'b1;
          // Truncation to ADDR_WIDTH gives the modulo wrap past the top of memory.
          mem_address_d    = BASE_ADDR + byte_count_q;
          mem_write_data_d = in_data;
          byte_count_d     = byte_count_q + ADDR_WIDTH'(1);
          sum_d            = sum_q + in_data;
          if (byte_count_q == len_q - ADDR_WIDTH'(1)) begin
            state_d = StCheck;
          end
        end
      end

      StCheck: begin
        if (xfer) begin
          if (in_data == sum_q) begin
            state_d    = StDone;
            done_d     = 1'b1;
            core_rst_d = 1'b0;
          end else begin
            state_d    = StError;
            error_d    = 1'b1;
            core_rst_d = 1'b1;
          end
        end
      end

      StDone, StError: begin
        if (restart) begin
          state_d      = StLenHi;
          len_d        = '0;
          sum_d        = '0;
          byte_count_d = '0;
          done_d       = 1'b0;
          error_d      = 1'b0;
          core_rst_d   = 1'b1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= StIdle;
      len_q            <= '0;
      sum_q            <= '0;
      byte_count_q     <= '0;
      mem_address_q    <= BASE_ADDR;
      mem_write_data_q <= '0;
      mem_write_q      <= 1'b0;
      core_rst_q       <= 1'b1;
      done_q           <= 1'b0;
      error_q          <= 1'b0;
    end else begin
      state_q          <= state_d;
      len_q            <= len_d;
      sum_q            <= sum_d;
      byte_count_q     <= byte_count_d;
      mem_address_q    <= mem_address_d;
      mem_write_data_q <= mem_write_data_d;
      mem_write_q      <= mem_write_d;
      core_rst_q       <= core_rst_d;
      done_q           <= done_d;
      error_q          <= error_d;
    end
  end

  assign mem_address    = mem_address_q;
  assign mem_write_data = mem_write_data_q;
  assign mem_write      = mem_write_q;
  assign core_rst       = core_rst_q;
  assign done           = done_q;
  assign error          = error_q;
  assign byte_count     = byte_count_q;

endmodule

// File: tb/tb_boot_loader.sv
// Bench for boot_loader: expected memory writes are queued as bytes are driven and matched
// against each mem_write strobe; status outputs are checked after each frame.
module tb_boot_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [7:0]  in_data = '0, in_data1 = '0;
  logic        in_valid = 1'b0, in_valid1 = 1'b0;
  logic        restart = 1'b0, restart1 = 1'b0;
  logic        in_ready, in_ready1;
  logic [12:0] mem_address, mem_address1;
  logic [7:0]  mem_write_data, mem_write_data1;
  logic        mem_write, mem_write1;
  logic        core_rst, core_rst1;
  logic        done, done1;
  logic        error, error1;
  logic [12:0] byte_count, byte_count1;

  int n_checks = 0;
  int n_fails  = 0;
  int cyc      = 0;

  logic [20:0] exp0_q[$];
  logic [20:0] exp1_q[$];
  int n_wr0 = 0, n_wr1 = 0;
  int last_wr_cyc0 = -10;
  int streak0 = 0;

  boot_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .restart       (restart),
    .mem_address   (mem_address),
    .mem_write_data(mem_write_data),
    .mem_write     (mem_write),
    .core_rst      (core_rst),
    .done          (done),
    .error         (error),
    .byte_count    (byte_count)
  );

  boot_loader #(.BASE_ADDR(13'h1FFF)) dut_wrap (
    .clk           (clk),
    .rst           (rst),
    .in_data       (in_data1),
    .in_valid      (in_valid1),
    .in_ready      (in_ready1),
    .restart       (restart1),
    .mem_address   (mem_address1),
    .mem_write_data(mem_write_data1),
    .mem_write     (mem_write1),
    .core_rst      (core_rst1),
    .done          (done1),
    .error         (error1),
    .byte_count    (byte_count1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: every write strobe must match the oldest queued {address, data}.
  always @(negedge clk) begin
    if (mem_write) begin
      n_wr0++;
      streak0 = (last_wr_cyc0 == cyc - 1) ? streak0 + 1 : 1;
      last_wr_cyc0 = cyc;
      if (exp0_q.size() == 0) check_eq("unexpected_write0", {11'b0, mem_address, mem_write_data}, 0);
      else check_eq("write0", {11'b0, mem_address, mem_write_data}, {11'b0, exp0_q.pop_front()});
    end
    if (mem_write1) begin
      n_wr1++;
      if (exp1_q.size() == 0) check_eq("unexpected_write1", {11'b0, mem_address1, mem_write_data1}, 0);
      else check_eq("write1", {11'b0, mem_address1, mem_write_data1}, {11'b0, exp1_q.pop_front()});
    end
  end

  function automatic logic rdy(input bit sel);
    return sel ? in_ready1 : in_ready;
  endfunction

  task automatic send(input bit sel, input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    if (sel) begin in_valid1 = 1'b1; in_data1 = b; end
    else begin in_valid = 1'b1; in_data = b; end
    while (!rdy(sel) && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("in_ready", {31'b0, rdy(sel)}, 1);
    @(posedge clk);
    #1;
    if (sel) in_valid1 = 1'b0;
    else in_valid = 1'b0;
  endtask

  task automatic push0(input logic [12:0] a, input logic [7:0] d);
    exp0_q.push_back({a, d});
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_restart();
    @(negedge clk);
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
  endtask

  task automatic good_frame();
    send(0, 8'h00); send(0, 8'h03);
    push0(13'h0, 8'hA1); send(0, 8'hA1);
    push0(13'h1, 8'hB2); send(0, 8'hB2);
    push0(13'h2, 8'hC3); send(0, 8'hC3);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_in_ready"},  {31'b0, in_ready}, 0);
    check_eq({tag, "_mem_write"}, {31'b0, mem_write}, 0);
    check_eq({tag, "_mem_addr"},  {19'b0, mem_address}, 0);
    check_eq({tag, "_mem_data"},  {24'b0, mem_write_data}, 0);
    check_eq({tag, "_core_rst"},  {31'b0, core_rst}, 1);
    check_eq({tag, "_done"},      {31'b0, done}, 0);
    check_eq({tag, "_error"},     {31'b0, error}, 0);
    check_eq({tag, "_count"},     {19'b0, byte_count}, 0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    check_eq("reset_wrap_addr", {19'b0, mem_address1}, 32'h1FFF);
    @(negedge clk);
    rst = 1'b0;
    idle(1);

    // 1) good three-byte frame, back-to-back
    good_frame();
    send(0, 8'h16);
    idle(2);
    check_eq("t1_done", {31'b0, done}, 1);
    check_eq("t1_core_rst", {31'b0, core_rst}, 0);
    check_eq("t1_count", {19'b0, byte_count}, 3);
    check_eq("t1_writes", n_wr0, 3);
    check_eq("t1_consecutive", streak0, 3);
    check_eq("t1_in_ready", {31'b0, in_ready}, 0);

    // 2) bad checksum, then restart and a good frame
    do_restart();
    check_eq("t2_restart_done", {31'b0, done}, 0);
    check_eq("t2_restart_core_rst", {31'b0, core_rst}, 1);
    check_eq("t2_restart_count", {19'b0, byte_count}, 0);
    w = n_wr0;
    good_frame();
    send(0, 8'h17);
    idle(2);
    check_eq("t2_error", {31'b0, error}, 1);
    check_eq("t2_core_rst", {31'b0, core_rst}, 1);
    check_eq("t2_done", {31'b0, done}, 0);
    check_eq("t2_writes", n_wr0 - w, 3);
    do_restart();
    check_eq("t2_error_cleared", {31'b0, error}, 0);
    good_frame();
    send(0, 8'h16);
    idle(2);
    check_eq("t2_done_after_restart", {31'b0, done}, 1);

    // 3) bad LEN_HI, then stream held off until restart
    do_restart();
    w = n_wr0;
    send(0, 8'h20);
    #1;
    check_eq("t3_error", {31'b0, error}, 1);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 8'h55;
    idle(3);
    check_eq("t3_in_ready_low", {31'b0, in_ready}, 0);
    check_eq("t3_still_error", {31'b0, error}, 1);
    check_eq("t3_no_writes", n_wr0 - w, 0);
    in_valid = 1'b0;

    // 4) zero-length frames
    do_restart();
    w = n_wr0;
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h00);
    idle(2);
    check_eq("t4_done", {31'b0, done}, 1);
    check_eq("t4_core_rst", {31'b0, core_rst}, 0);
    do_restart();
    send(0, 8'h00); send(0, 8'h00); send(0, 8'h05);
    idle(2);
    check_eq("t4_error", {31'b0, error}, 1);
    check_eq("t4_no_writes", n_wr0 - w, 0);

    // 5) address wrap at top of memory with gapped stream
    send(1, 8'h00); idle(1);
    send(1, 8'h02); idle(1);
    exp1_q.push_back({13'h1FFF, 8'h11}); send(1, 8'h11); idle(2);
    exp1_q.push_back({13'h0000, 8'h22}); send(1, 8'h22); idle(1);
    send(1, 8'h33);
    idle(2);
    check_eq("t5_done", {31'b0, done1}, 1);
    check_eq("t5_writes", n_wr1, 2);
    check_eq("t5_count", {19'b0, byte_count1}, 2);

    // 6) async reset in mid-image, then a clean load
    do_restart();
    w = n_wr0;
    send(0, 8'h00); send(0, 8'h03);
    push0(13'h0, 8'hA1); send(0, 8'hA1);
    push0(13'h1, 8'hB2); send(0, 8'hB2);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_reset_values("t6_rst");
    check_eq("t6_partial_writes", n_wr0 - w, 2);
    @(negedge clk);
    rst = 1'b0;
    idle(1);
    good_frame();
    send(0, 8'h16);
    idle(2);
    check_eq("t6_done", {31'b0, done}, 1);
    check_eq("t6_count", {19'b0, byte_count}, 3);
    check_eq("t6_writes", n_wr0 - w, 5);

    check_eq("queue0_drained", exp0_q.size(), 0);
    check_eq("queue1_drained", exp1_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
